// File: rtl/serial_eq_checker.sv
// Serial word comparator: accepts WIDTH bit pairs LSB first and reports
// equality, mismatch count and the index of the first differing bit.
module serial_eq_checker #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a,
  input  logic          b,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] mismatches,
  output logic [CW-1:0] first_diff,
  output logic          match_bit
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_C  = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          equal_q, equal_d;
  logic [CW-1:0] mism_q, mism_d;
  logic [CW-1:0] fdiff_q, fdiff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match_q, match_d;
  logic          launch;

  // A new word can be launched from IDLE, or straight from DONE when the
  // consumer acknowledges and requests another comparison in the same cycle.
  assign launch = start && ((state_q == IDLE) || (state_q == DONE && ack));

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    equal_d = equal_q;
    mism_d  = mism_q;
    fdiff_d = fdiff_q;
    cnt_d   = cnt_q;
    match_d = match_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (bit_valid) begin
          match_d = ~(a ^ b);
          if (a ^ b) begin
            mism_d = mism_q + CW'(1);
            if (fdiff_q == WIDTH_C) fdiff_d = cnt_q;
          end
          // Counter parks at the last index; it never wraps within a word.
          if (cnt_q == LAST_C) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            equal_d = (mism_d == '0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (ack) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = RUN;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      equal_d = 1'b0;
      mism_d  = '0;
      fdiff_d = WIDTH_C;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      mism_q  <= '0;
      fdiff_q <= WIDTH_C;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      mism_q  <= mism_d;
      fdiff_q <= fdiff_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign equal      = equal_q;
  assign mismatches = mism_q;
  assign first_diff = fdiff_q;
  assign match_bit  = match_q;

endmodule

// File: tb/tb_serial_eq_checker.sv
// Directed bench for serial_eq_checker (WIDTH=8): table of words plus
// hand-written stall, reset and DONE-hold sequences.
module tb_serial_eq_checker;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          bit_valid;
  logic          a;
  logic          b;
  logic          ack;
  logic          busy;
  logic          done;
  logic          equal;
  logic [CW-1:0] mismatches;
  logic [CW-1:0] first_diff;
  logic          match_bit;

  int errors;
  int checks;

  serial_eq_checker #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bit_valid  (bit_valid),
    .a          (a),
    .b          (b),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .mismatches (mismatches),
    .first_diff (first_diff),
    .match_bit  (match_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wb;
    int         stall_after;
    int         stall_len;
    logic       exp_equal;
    int         exp_mism;
    int         exp_fdiff;
    logic       exp_match;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a word from IDLE and feed its 8 bits; optional stall with
  // start/ack held high to show they are ignored while running.
  task automatic feed_word(input logic [7:0] wa, input logic [7:0] wb,
                           input int stall_after, input int stall_len,
                           input string tag);
    int snap;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_start"}, busy, 1);
    chk({tag, ".mism_clear"}, mismatches, 0);
    chk({tag, ".fdiff_clear"}, first_diff, WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      a = wa[i];
      b = wb[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      if (i < WIDTH - 1) chk({tag, ".done_early"}, done, 0);
      if (i == stall_after) begin
        snap = int'(mismatches);
        start = 1'b1;
        ack = 1'b1;
        a = ~a;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk({tag, ".stall_busy"}, busy, 1);
          chk({tag, ".stall_mism"}, mismatches, snap);
        end
        start = 1'b0;
        ack = 1'b0;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic eq, input int mm,
                              input int fd);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".equal"}, equal, eq);
    chk({tag, ".mismatches"}, mismatches, mm);
    chk({tag, ".first_diff"}, first_diff, fd);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    a = 1'b0;
    b = 1'b0;
    ack = 1'b0;

    vecs[0] = '{8'hA5, 8'hA5, -1, 0, 1'b1, 0, 8, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, -1, 0, 1'b0, 8, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'h7F, -1, 0, 1'b0, 1, 7, 1'b0};
    vecs[3] = '{8'h3C, 8'h3C,  2, 3, 1'b1, 0, 8, 1'b1};
    vecs[4] = '{8'h00, 8'h01, -1, 0, 1'b0, 1, 0, 1'b1};
    vecs[5] = '{8'h12, 8'h30, -1, 0, 1'b0, 2, 1, 1'b1};

    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.equal", equal, 0);
    chk("rst.mismatches", mismatches, 0);
    chk("rst.first_diff", first_diff, WIDTH);
    chk("rst.match_bit", match_bit, 0);
    reset_n = 1'b1;

    // ack in IDLE is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack.busy", busy, 0);
    chk("idle_ack.done", done, 0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      feed_word(vecs[v].wa, vecs[v].wb, vecs[v].stall_after, vecs[v].stall_len, tag);
      check_result(tag, vecs[v].exp_equal, vecs[v].exp_mism, vecs[v].exp_fdiff);
      chk({tag, ".match_bit"}, match_bit, vecs[v].exp_match);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk({tag, ".ack_done"}, done, 0);
      chk({tag, ".ack_busy"}, busy, 0);
      chk({tag, ".ack_keep_mism"}, mismatches, vecs[v].exp_mism);
      chk({tag, ".ack_keep_fdiff"}, first_diff, vecs[v].exp_fdiff);
    end

    // Reset mid-word, asserted together with start/bit_valid to show priority.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 1'b1;
      b = 1'b0;
      bit_valid = 1'b1;
      tick();
    end
    chk("midrst.pre_mism", mismatches, 4);
    reset_n = 1'b0;
    start = 1'b1;
    tick();
    reset_n = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.mismatches", mismatches, 0);
    chk("midrst.first_diff", first_diff, WIDTH);
    chk("midrst.match_bit", match_bit, 0);
    tick();
    chk("midrst.idle_busy", busy, 0);
    feed_word(8'h81, 8'h80, -1, 0, "postrst");
    check_result("postrst", 1'b0, 1, 0);

    // Hold DONE for 5 cycles with noise on every ignored input.
    for (int s = 0; s < 5; s++) begin
      start = 1'b1;
      bit_valid = 1'b1;
      a = s[0];
      b = ~s[0];
      tick();
      check_result($sformatf("hold%0d", s), 1'b0, 1, 0);
    end
    ack = 1'b1;
    start = 1'b1;
    bit_valid = 1'b0;
    tick();
    ack = 1'b0;
    start = 1'b0;
    chk("restart.busy", busy, 1);
    chk("restart.done", done, 0);
    chk("restart.mismatches", mismatches, 0);
    chk("restart.first_diff", first_diff, WIDTH);
    chk("restart.equal", equal, 0);
    for (int i = 0; i < WIDTH; i++) begin
      a = (i == 6);
      b = 1'b0;
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    check_result("restart_word", 1'b0, 1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_eq_checker.md
SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bit pairs per compared word (2..255).
REQ-002 SHALL have parameter CW, default 4: width of count/index outputs, equal to clog2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1: begin a new word comparison.
REQ-006 SHALL have port bit_valid  input  1: a/b carry a valid bit pair this cycle.
REQ-007 SHALL have port a  input  1: serial bit of word A, LSB first.
REQ-008 SHALL have port b  input  1: serial bit of word B, LSB first.
REQ-009 SHALL have port ack  input  1: consumer acknowledges result.
REQ-010 SHALL have port busy  output  1: high in RUN.
REQ-011 SHALL have port done  output  1: high in DONE, result valid.
REQ-012 SHALL have port equal  output  1: all WIDTH bit pairs matched (XNOR=1).
REQ-013 SHALL have port mismatches  output  CW: count of bit pairs with a!=b.
REQ-014 SHALL have port first_diff  output  CW: bit index of first mismatch; WIDTH if none.
REQ-015 SHALL have port match_bit  output  1: registered XNOR of last accepted pair.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE: start=1 -> RUN next cycle; bit counter, mismatches cleared to 0; first_diff set to WIDTH; equal cleared to 0.
REQ-018 RUN: bit pair accepted only when bit_valid=1; bit_valid=0 holds all state (stall, no timeout).
REQ-019 Per accepted pair: match_bit <= ~(a^b); if a!=b mismatches increments by 1 and, if first_diff==WIDTH, first_diff <= current bit index.
REQ-020 Bit index counts 0..WIDTH-1; pair accepted at index WIDTH-1 -> DONE next cycle; counter SHALL not wrap within a word.
REQ-021 mismatches SHALL not overflow: maximum value WIDTH fits in CW bits.
REQ-022 Entering DONE: equal <= (final mismatches==0); done=1, busy=0.
REQ-023 Latency: done asserted on the cycle after the WIDTH-th accepted pair.
REQ-024 DONE: equal, mismatches, first_diff, done held stable until ack=1; bit_valid, a, b ignored.
REQ-025 DONE with ack=1, start=0 -> IDLE; result outputs retain values, done drops.
REQ-026 DONE with ack=1 and start=1 same cycle -> RUN directly, clears per REQ-017.
REQ-027 start ignored in RUN; start in DONE without ack ignored.
REQ-028 ack ignored in IDLE and RUN.

Reset
REQ-029 reset_n=0 sampled at a clock edge SHALL force IDLE regardless of state, including mid-RUN.
REQ-030 Reset values: busy=0, done=0, equal=0, mismatches=0, first_diff=WIDTH, match_bit=0, bit counter 0.
REQ-031 Reset has priority over start, ack, bit_valid in the same cycle; a partially compared word is discarded.

Verification (WIDTH=8)
REQ-032 start, then A=0xA5, B=0xA5 over 8 consecutive valid cycles -> done=1 one cycle later, equal=1, mismatches=0, first_diff=8.
REQ-033 A=0xA5, B=0x5A -> equal=0, mismatches=8, first_diff=0; A=0xFF, B=0x7F -> mismatches=1, first_diff=7.
REQ-034 A=B=0x3C with bit_valid low for 3 cycles after bit 2 -> busy held, done exactly one cycle after 8th valid pair, equal=1.
REQ-035 reset_n=0 after 4 accepted pairs -> next cycle busy=0, done=0, mismatches=0, first_diff=8; new start completes normally.
REQ-036 In DONE hold ack=0 for 5 cycles -> outputs stable; then ack=1 with start=1 -> busy=1 next cycle, mismatches=0, first_diff=8.
